mac_accum: RTL

Signed fixed-point multiply-accumulate stage that sits directly upstream of the 26-bit output register in the datapath. It consumes one pair of registered 19-bit operands per cycle and accumulates their scaled products over a vector delimited by `in_last`. It emits one saturated 26-bit sum per vector, plus a term count and a saturation flag, as a single-cycle valid pulse. There is no backpressure: the downstream register captures every `out_valid` cycle.

---
 rtl/mac_accum_if.sv | 25 ++
 rtl/mac_accum.sv | 102 ++++++++++
 2 files changed

// File: rtl/mac_accum_if.sv
// Operand/result bundle for mac_accum: master drives operands, slave returns per-vector results.
interface mac_accum_if #(
  parameter int unsigned IN_W  = 19,
  parameter int unsigned ACC_W = 26,
  parameter int unsigned CNT_W = 8
);
  logic                    in_valid;
  logic                    in_last;
  logic signed [IN_W-1:0]  in_a;
  logic signed [IN_W-1:0]  in_b;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0]        out_count;
  logic                    out_sat;

  modport master (
    output in_valid, in_last, in_a, in_b,
    input  out_valid, out_sum, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_last, in_a, in_b,
    output out_valid, out_sum, out_count, out_sat
  );
endinterface

// File: rtl/mac_accum.sv
// Two-stage signed fixed-point MAC: saturated scaled product, then saturating per-vector
// accumulation emitting one sum/count/sat result pulse per in_last-terminated vector.
module mac_accum #(
  parameter int unsigned IN_W  = 19,
  parameter int unsigned ACC_W = 26,
  parameter int unsigned FRAC  = 12,
  parameter int unsigned CNT_W = 8
) (
  input logic       clk,
  input logic       rst,
  mac_accum_if.slave io_bus
);
  localparam int unsigned PW = 2 * IN_W;
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  // Stage 1: full-width product, truncating shift, clamp to accumulator range
  logic signed [PW-1:0]    w_a_ext, w_b_ext, w_prod, w_prod_shr;
  logic                    w_prod_ovf;
  logic signed [ACC_W-1:0] w_prod_sat;

  always_comb begin
    w_a_ext    = PW'(io_bus.in_a);
    w_b_ext    = PW'(io_bus.in_b);
    w_prod     = w_a_ext * w_b_ext;
    w_prod_shr = w_prod >>> FRAC;
    w_prod_ovf = (w_prod_shr[PW-1:ACC_W-1] != {(PW-ACC_W+1){w_prod_shr[PW-1]}});
    w_prod_sat = w_prod_ovf ? (w_prod_shr[PW-1] ? AccMin : AccMax) : w_prod_shr[ACC_W-1:0];
  end

  logic signed [ACC_W-1:0] r_p;
  logic                    r_p_valid, r_p_last, r_p_sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p       <= '0;
      r_p_valid <= 1'b0;
      r_p_last  <= 1'b0;
      r_p_sat   <= 1'b0;
    end else begin
      r_p_valid <= io_bus.in_valid;
      r_p_last  <= io_bus.in_valid & io_bus.in_last;
      if (io_bus.in_valid) begin
        r_p     <= w_prod_sat;
        r_p_sat <= w_prod_ovf;
      end
    end
  end

  // Stage 2: one guard bit detects accumulator overflow before clamping
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sat_flag, r_start;
  logic                    r_out_valid, r_out_sat;
  logic signed [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0]        r_out_count;

  logic signed [ACC_W-1:0] w_base, w_acc_nxt;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_sum_ovf, w_sat_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;

  always_comb begin
    w_base    = r_start ? '0 : r_acc;
    w_sum     = (ACC_W+1)'(w_base) + (ACC_W+1)'(r_p);
    w_sum_ovf = (w_sum[ACC_W] != w_sum[ACC_W-1]);
    w_acc_nxt = w_sum_ovf ? (w_sum[ACC_W] ? AccMin : AccMax) : w_sum[ACC_W-1:0];
    w_cnt_nxt = r_start ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));
    w_sat_nxt = (~r_start & r_sat_flag) | r_p_sat | w_sum_ovf;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat_flag  <= 1'b0;
      r_start     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_out_valid <= r_p_valid & r_p_last;
      if (r_p_valid) begin
        r_acc      <= w_acc_nxt;
        r_cnt      <= w_cnt_nxt;
        r_sat_flag <= w_sat_nxt;
        r_start    <= r_p_last;
        if (r_p_last) begin
          r_out_sum   <= w_acc_nxt;
          r_out_count <= w_cnt_nxt;
          r_out_sat   <= w_sat_nxt;
        end
      end
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_sum   = r_out_sum;
  assign io_bus.out_count = r_out_count;
  assign io_bus.out_sat   = r_out_sat;
endmodule
